// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the DMA master state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_D = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_D = 3'd4,
      ST_FIN  = 3'd5
   } dma_state_t;

endpackage

// File: rtl/ahb_dma_master.sv
// AHB-Lite DMA master: word-by-word copy using single read then single write.
// Define AHB_DMA_ERR_EN to abort the copy on an ERROR response and flag err.
module ahb_dma_master
   import ahb_pkg::*;
#(
   parameter int LEN_W = 16
)
(
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] word_count,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [31:0]      HWDATA,
   input  logic             HREADY,
   input  logic [31:0]      HRDATA,
   input  logic             HRESP,
   output logic [2:0]       dbg_state
);

   dma_state_t       state;
   htrans_t          htrans_q;
   logic [31:0]      src_q, dst_q, buf_q, haddr_q, hwdata_q;
   logic [LEN_W-1:0] rem_q;
   logic             hwrite_q, busy_q, done_q;
   logic             data_phase, err_stall, err_abort;

   // Handshake: an address or data phase completes only in a cycle where
   // HREADY=1; while HREADY=0 every state and bus output holds its value.
   assign data_phase = (state == ST_RD_D) || (state == ST_WR_D);

`ifdef AHB_DMA_ERR_EN
   logic err_q, err_pend;

   assign err_stall = data_phase && HRESP && !HREADY;
   assign err_abort = data_phase && HREADY && (HRESP || err_pend);
   // First ERROR cycle must already show IDLE, so mask the registered value.
   assign HTRANS    = err_stall ? HTRANS_IDLE : htrans_q;
   assign err       = err_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_q    <= 1'b0;
         err_pend <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) err_q <= 1'b0;
         else if (err_abort)            err_q <= 1'b1;
         if (err_abort)                 err_pend <= 1'b0;
         else if (err_stall)            err_pend <= 1'b1;
      end
   end
`else
   logic unused_hresp;

   assign unused_hresp = HRESP ^ data_phase;
   assign err_stall    = 1'b0;
   assign err_abort    = 1'b0;
   assign HTRANS       = htrans_q;
   assign err          = 1'b0;
`endif

   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HSIZE     = HSIZE_WORD;
   assign HBURST    = HBURST_SINGLE;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         htrans_q <= HTRANS_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         buf_q    <= '0;
         haddr_q  <= '0;
         hwdata_q <= '0;
         rem_q    <= '0;
         hwrite_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (err_abort) begin
         state    <= ST_FIN;
         htrans_q <= HTRANS_IDLE;
         done_q   <= 1'b1;
      end else if (err_stall) begin
         htrans_q <= HTRANS_IDLE;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     src_q    <= src_addr & WORD_ADDR_MASK;
                     dst_q    <= dst_addr & WORD_ADDR_MASK;
                     rem_q    <= word_count;
                     haddr_q  <= src_addr & WORD_ADDR_MASK;
                     htrans_q <= HTRANS_NONSEQ;
                     hwrite_q <= 1'b0;
                     busy_q   <= 1'b1;
                     state    <= ST_RD_A;
                  end else begin
                     done_q <= 1'b1;
                     state  <= ST_FIN;
                  end
               end
            end
            ST_RD_A: begin
               if (HREADY) begin
                  htrans_q <= HTRANS_IDLE;
                  state    <= ST_RD_D;
               end
            end
            ST_RD_D: begin
               if (HREADY) begin
                  buf_q    <= HRDATA;
                  haddr_q  <= dst_q;
                  htrans_q <= HTRANS_NONSEQ;
                  hwrite_q <= 1'b1;
                  state    <= ST_WR_A;
               end
            end
            ST_WR_A: begin
               if (HREADY) begin
                  hwdata_q <= buf_q;
                  src_q    <= src_q + 32'd4;
                  dst_q    <= dst_q + 32'd4;
                  rem_q    <= rem_q - LEN_W'(1);
                  state    <= ST_WR_D;
                  // Overlap the next read address with this write's data phase.
                  if (rem_q == LEN_W'(1)) begin
                     htrans_q <= HTRANS_IDLE;
                  end else begin
                     htrans_q <= HTRANS_NONSEQ;
                     hwrite_q <= 1'b0;
                     haddr_q  <= src_q + 32'd4;
                  end
               end
            end
            ST_WR_D: begin
               if (HREADY) begin
                  htrans_q <= HTRANS_IDLE;
                  if (rem_q != '0) begin
                     state <= ST_RD_D;
                  end else begin
                     done_q <= 1'b1;
                     state  <= ST_FIN;
                  end
               end
            end
            ST_FIN: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Directed bench for ahb_dma_master with an AHB RAM slave model and write scoreboard.
module tb_ahb_dma_master;

   localparam int LEN_W = 16;

   logic             HCLK = 1'b0;
   logic             HRESETn = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [LEN_W-1:0] word_count = '0;
   logic             busy, done, err, HWRITE;
   logic [31:0]      HADDR, HWDATA;
   logic [1:0]       HTRANS;
   logic [2:0]       HSIZE, HBURST, dbg_state;
   logic             HREADY, HRESP;
   logic [31:0]      HRDATA;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [31:0] mem [logic [31:0]];
   int rd_waits = 0;
   int wr_waits = 0;
   int rd_cnt   = 0;
   logic        err_armed = 1'b0;
   logic [31:0] err_addr  = '0;

   ahb_dma_master #(.LEN_W(LEN_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .word_count(word_count), .busy(busy), .done(done),
      .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
      .HRESP(HRESP), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // AHB-Lite RAM slave model with programmable wait states and ERROR injection
   logic        dp_valid, dp_write, dp_err, prev_ready;
   logic [31:0] dp_addr;
   logic [34:0] prev_ctl;
   int          ws;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         HREADY     <= 1'b1;
         HRESP      <= 1'b0;
         HRDATA     <= '0;
         dp_valid   <= 1'b0;
         dp_write   <= 1'b0;
         dp_err     <= 1'b0;
         dp_addr    <= '0;
         ws         <= 0;
         prev_ready <= 1'b1;
         prev_ctl   <= '0;
      end else begin
         if (!prev_ready)
            check("ctl_stable", 64'({HTRANS, HWRITE, HADDR}), 64'(prev_ctl));
         if (HRESP && !HREADY)
            check("err_htrans_idle", 64'(HTRANS), 64'(2'b00));
         prev_ready <= HREADY;
         prev_ctl   <= {HTRANS, HWRITE, HADDR};
         if (!HREADY) begin
            if (dp_err) begin
               HREADY <= 1'b1;
               HRESP  <= 1'b1;
            end else begin
               ws     <= ws - 1;
               HREADY <= (ws == 1);
            end
         end else begin
            HRESP <= 1'b0;
            if (dp_valid && dp_write && !dp_err) begin
               mem[dp_addr] = HWDATA;
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 64'({dp_addr, HWDATA}), 64'(0));
               end else begin
                  check("wr_addr_data", {dp_addr, HWDATA}, exp_q.pop_front());
               end
            end
            dp_valid <= 1'b0;
            dp_err   <= 1'b0;
            HREADY   <= 1'b1;
            if (HTRANS == 2'b10) begin
               dp_valid <= 1'b1;
               dp_addr  <= HADDR;
               dp_write <= HWRITE;
               HRDATA   <= rd_mem(HADDR);
               if (!HWRITE) rd_cnt++;
               if (HWRITE && err_armed && HADDR == err_addr) begin
                  err_armed = 1'b0;
                  dp_err <= 1'b1;
                  HREADY <= 1'b0;
                  HRESP  <= 1'b1;
               end else begin
                  ws     <= HWRITE ? wr_waits : rd_waits;
                  HREADY <= ((HWRITE ? wr_waits : rd_waits) == 0);
               end
            end
         end
      end
   end

   // driver: load source words, push expected writes, pulse start, time done
   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                           input int n_wr, input int n_rd, input int exp_cyc);
      int c, rd0, busy_gap;
      logic [31:0] d;
      for (int i = 0; i < cnt; i++) begin
         d = $urandom;
         mem[src + 32'(4 * i)] = d;
         if (i < n_wr) exp_q.push_back({(dst & 32'hFFFF_FFFC) + 32'(4 * i), d});
      end
      rd0 = rd_cnt;
      busy_gap = 0;
      @(negedge HCLK);
      start = 1'b1; src_addr = src; dst_addr = dst; word_count = LEN_W'(cnt);
      @(posedge HCLK); #1;
      start = 1'b0; src_addr = $urandom; dst_addr = $urandom; word_count = LEN_W'($urandom);
      c = 1;
      check("err_cleared", 64'(err), 64'(0));
      while (!done && c < exp_cyc + 20) begin
         if (cnt != 0 && busy !== 1'b1) busy_gap++;
         @(posedge HCLK); #1;
         c++;
      end
      check("done_seen", 64'(done), 64'(1));
      check("done_cycle", 64'(c), 64'(exp_cyc));
      check("busy_during", 64'(busy_gap), 64'(0));
      check("busy_at_done", 64'(busy), 64'(cnt != 0));
      check("read_count", 64'(rd_cnt - rd0), 64'(n_rd));
      @(posedge HCLK); #1;
      check("done_pulse", 64'(done), 64'(0));
      check("busy_after", 64'(busy), 64'(0));
      check("sb_empty", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   initial begin
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_htrans", 64'(HTRANS), 64'(0));
      check("rst_haddr",  64'(HADDR),  64'(0));
      check("rst_hwrite", 64'(HWRITE), 64'(0));
      check("rst_hwdata", 64'(HWDATA), 64'(0));
      check("rst_busy",   64'(busy),   64'(0));
      check("rst_done",   64'(done),   64'(0));
      check("rst_err",    64'(err),    64'(0));
      check("hsize",      64'(HSIZE),  64'(3'b010));
      check("hburst",     64'(HBURST), 64'(3'b000));
      @(negedge HCLK);
      HRESETn = 1'b1;

      run_copy(32'h0000_0000, 32'h0000_0100, 4, 4, 4, 14);
      run_copy(32'h0000_0200, 32'h0000_0300, 0, 0, 0, 1);
      rd_waits = 2;
      run_copy(32'h0000_0400, 32'h0000_0500, 3, 3, 3, 17);
      rd_waits = 0;
      run_copy(32'hFFFF_FFFC, 32'h0000_0103, 2, 2, 2, 8);
      wr_waits = 1;
      run_copy(32'h0000_0600, 32'h0000_0700, 2, 2, 2, 10);
      wr_waits = 0;

`ifdef AHB_DMA_ERR_EN
      err_addr  = 32'h0000_0904;
      err_armed = 1'b1;
      run_copy(32'h0000_0800, 32'h0000_0900, 4, 1, 2, 9);
      check("err_sticky", 64'(err), 64'(1));
      run_copy(32'h0000_0A00, 32'h0000_0B00, 1, 1, 1, 5);
      check("err_after_clean", 64'(err), 64'(0));
`endif

      // reset in the first read data phase
      for (int i = 0; i < 4; i++) mem[32'h0000_0C00 + 32'(4 * i)] = $urandom;
      @(negedge HCLK);
      start = 1'b1; src_addr = 32'h0000_0C00; dst_addr = 32'h0000_0D00; word_count = LEN_W'(4);
      @(posedge HCLK); #1;
      start = 1'b0;
      @(posedge HCLK); #1;
      check("pre_rst_state_rd_d", 64'(dbg_state), 64'(3'd2));
      #2 HRESETn = 1'b0;
      #1;
      check("arst_htrans", 64'(HTRANS), 64'(0));
      check("arst_busy",   64'(busy),   64'(0));
      check("arst_haddr",  64'(HADDR),  64'(0));
      check("arst_hwdata", 64'(HWDATA), 64'(0));
      check("arst_state",  64'(dbg_state), 64'(3'd0));
      repeat (2) @(posedge HCLK);
      #1;
      check("arst_no_done", 64'(done), 64'(0));
      @(negedge HCLK);
      HRESETn = 1'b1;
      exp_q.delete();
      run_copy(32'h0000_0C00, 32'h0000_0D00, 2, 2, 2, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
